// File: rtl/matmul_result_drain_if.sv
// Stream bundle for the result drain: vector capture side and element beat side.
// master = producer/consumer environment, slave = the drain block.
interface matmul_result_drain_if #(
  parameter int NUM_OUT   = 4,
  parameter int ACC_WIDTH = 24,
  parameter int OUT_WIDTH = 16
);
  localparam int IDX_W = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;

  logic                         in_valid;
  logic                         in_ready;
  logic [NUM_OUT*ACC_WIDTH-1:0] in_data;
  logic                         out_valid;
  logic                         out_ready;
  logic [OUT_WIDTH-1:0]         out_data;
  logic [IDX_W-1:0]             out_idx;
  logic                         out_last;
  logic                         busy;
  logic [15:0]                  sat_count;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_idx, out_last, busy, sat_count
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_idx, out_last, busy, sat_count
  );
endinterface

// File: rtl/matmul_result_drain.sv
// Result drain: captures a full accumulator vector, requantizes every lane
// (arithmetic shift + saturate) and streams one element per valid/ready beat.
module matmul_result_drain #(
  parameter int NUM_OUT   = 4,
  parameter int ACC_WIDTH = 24,
  parameter int OUT_WIDTH = 16,
  parameter int SHIFT     = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  matmul_result_drain_if.slave   bus
);
  localparam int IDX_W = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_OUT - 1);
  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX = ACC_WIDTH'((1 << (OUT_WIDTH-1)) - 1);
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = ACC_WIDTH'(-(1 << (OUT_WIDTH-1)));

  typedef enum logic {IDLE, DRAIN} state_e;

  state_e                              state_q, state_d;
  logic [IDX_W-1:0]                    idx_q, idx_d;
  logic [NUM_OUT-1:0][ACC_WIDTH-1:0]   buf_q, buf_d;
  logic [15:0]                         sat_cnt_q, sat_cnt_d;

  logic [NUM_OUT-1:0][OUT_WIDTH-1:0]   q_data;
  logic [NUM_OUT-1:0]                  q_hi, q_lo;
  logic                                drain, last, out_fire, in_fire, sat_hit;

  // Per-lane requantization of the registered buffer; only the selected lane is used.
  for (genvar k = 0; k < NUM_OUT; k++) begin : g_lane
    logic signed [ACC_WIDTH-1:0] sh;
    assign sh        = $signed(buf_q[k]) >>> SHIFT;
    assign q_hi[k]   = sh > SAT_MAX;
    assign q_lo[k]   = sh < SAT_MIN;
    assign q_data[k] = q_hi[k] ? SAT_MAX[OUT_WIDTH-1:0] :
                       q_lo[k] ? SAT_MIN[OUT_WIDTH-1:0] : sh[OUT_WIDTH-1:0];
  end

  assign drain    = (state_q == DRAIN);
  assign last     = drain && (idx_q == LAST_IDX);
  assign out_fire = drain && bus.out_ready;
  assign in_fire  = bus.in_valid && bus.in_ready;
  assign sat_hit  = q_hi[idx_q] | q_lo[idx_q];

  assign bus.in_ready  = !drain || (last && bus.out_ready);
  assign bus.out_valid = drain;
  assign bus.out_data  = drain ? q_data[idx_q] : '0;
  assign bus.out_idx   = drain ? idx_q : '0;
  assign bus.out_last  = last;
  assign bus.busy      = drain;
  assign bus.sat_count = sat_cnt_q;

  // Next state: capture wins over the final-beat return to IDLE so vectors chain without bubbles.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    buf_d     = buf_q;
    sat_cnt_d = sat_cnt_q;
    if (in_fire) begin
      buf_d   = bus.in_data;
      idx_d   = '0;
      state_d = DRAIN;
    end else if (out_fire) begin
      if (last) begin
        idx_d   = '0;
        state_d = IDLE;
      end else begin
        idx_d = idx_q + 1'b1;
      end
    end
    if (out_fire && sat_hit && sat_cnt_q != 16'hFFFF)
      sat_cnt_d = sat_cnt_q + 16'd1;
  end

  // State registers; reset drops any buffered vector.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      buf_q     <= '0;
      sat_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      buf_q     <= buf_d;
      sat_cnt_q <= sat_cnt_d;
    end
  end
endmodule

// File: tb/tb_matmul_result_drain.sv
// Bench: two drains (SHIFT=0 and SHIFT=4) share one stimulus stream; a queue-based
// model of pending elements predicts every output each cycle.
module tb_matmul_result_drain;
  localparam int N = 4, AW = 24, OW = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic [N*AW-1:0] in_data = '0;
  logic out_ready = 1'b1;
  int   out_mode = 0;
  bit   mon_en = 1'b0;
  int   errs = 0, checks = 0;

  always #5 clk = ~clk;

  matmul_result_drain_if #(.NUM_OUT(N), .ACC_WIDTH(AW), .OUT_WIDTH(OW)) if0 ();
  matmul_result_drain_if #(.NUM_OUT(N), .ACC_WIDTH(AW), .OUT_WIDTH(OW)) if1 ();

  assign if0.in_valid = in_valid;  assign if1.in_valid = in_valid;
  assign if0.in_data  = in_data;   assign if1.in_data  = in_data;
  assign if0.out_ready = out_ready; assign if1.out_ready = out_ready;

  matmul_result_drain #(.NUM_OUT(N), .ACC_WIDTH(AW), .OUT_WIDTH(OW), .SHIFT(0))
    u_dut0 (.clk(clk), .rst(rst), .bus(if0));
  matmul_result_drain #(.NUM_OUT(N), .ACC_WIDTH(AW), .OUT_WIDTH(OW), .SHIFT(4))
    u_dut1 (.clk(clk), .rst(rst), .bus(if1));

  task automatic chk(input string tag, input longint obs, input longint exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int quant(input longint x, input int sh, output bit s);
    longint y;
    y = x >>> sh;
    s = 1'b0;
    if (y > 32767) begin s = 1'b1; return 32767; end
    if (y < -32768) begin s = 1'b1; return -32768; end
    return int'(y);
  endfunction

  typedef struct {int d0; int d1; bit s0; bit s1; int idx; bit last;} beat_t;
  beat_t bq[$];
  int    sat0 = 0, sat1 = 0;
  bit    exp_v, exp_ir;
  beat_t b;

  // Reference: remaining beats of the current vector; a vector is taken when in_ready is predicted.
  always @(negedge clk) if (mon_en) begin
    exp_v  = bq.size() > 0;
    exp_ir = !exp_v || (bq[0].last && out_ready);
    chk("in_ready0", if0.in_ready, exp_ir);
    chk("in_ready1", if1.in_ready, exp_ir);
    chk("out_valid0", if0.out_valid, exp_v);
    chk("out_valid1", if1.out_valid, exp_v);
    chk("busy0", if0.busy, exp_v);
    chk("sat_count0", if0.sat_count, sat0);
    chk("sat_count1", if1.sat_count, sat1);
    if (exp_v) begin
      chk("out_data0", int'($signed(if0.out_data)), bq[0].d0);
      chk("out_data1", int'($signed(if1.out_data)), bq[0].d1);
      chk("out_idx0", if0.out_idx, bq[0].idx);
      chk("out_last0", if0.out_last, bq[0].last);
      chk("out_last1", if1.out_last, bq[0].last);
    end else begin
      chk("idle_data0", if0.out_data, 0);
      chk("idle_idx0", if0.out_idx, 0);
      chk("idle_last0", if0.out_last, 0);
    end
    if (rst) begin
      bq.delete();
      sat0 = 0;
      sat1 = 0;
    end else begin
      if (exp_v && out_ready) begin
        b = bq.pop_front();
        if (b.s0 && sat0 < 65535) sat0++;
        if (b.s1 && sat1 < 65535) sat1++;
      end
      if (in_valid && exp_ir) begin
        for (int k = 0; k < N; k++) begin
          longint x;
          x = longint'($signed(in_data[k*AW +: AW]));
          b.d0 = quant(x, 0, b.s0);
          b.d1 = quant(x, 4, b.s1);
          b.idx = k;
          b.last = (k == N-1);
          bq.push_back(b);
        end
      end
    end
  end

  // Consumer: always ready, 1-of-3 ready, or random ready.
  initial begin
    int ph;
    ph = 0;
    forever begin
      @(posedge clk); #1;
      case (out_mode)
        0: out_ready = 1'b1;
        1: begin out_ready = (ph == 0); ph = (ph + 1) % 3; end
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  function automatic logic [N*AW-1:0] pk(input int a, input int b2, input int c, input int d);
    logic [N*AW-1:0] v;
    v[0*AW +: AW] = AW'(a);
    v[1*AW +: AW] = AW'(b2);
    v[2*AW +: AW] = AW'(c);
    v[3*AW +: AW] = AW'(d);
    return v;
  endfunction

  task automatic send(input logic [N*AW-1:0] v);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = v;
    @(negedge clk);
    while (!if0.in_ready && n < 64) begin n++; @(negedge clk); end
    chk("send_accept", if0.in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data  = {$urandom, $urandom, $urandom};
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (if0.out_valid && n < 200) begin n++; @(negedge clk); end
    chk("drain_done", if0.out_valid, 0);
    @(posedge clk); #1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    mon_en = 1'b1;

    out_mode = 0;
    send(pk(10, -5, 0, 32767));                       wait_idle();
    send(pk(40000, -40000, -32768, 100));             wait_idle();
    send(pk(32'h000100, -17, 15, 32'h7FFFFF));        wait_idle();

    out_mode = 1;
    send(pk(1, -2, 3, 70000));
    send(pk(-100000, 5, 6, 7));                       wait_idle();

    // Reset in the middle of a drain, then a fresh vector starts at element 0.
    send(pk(111, 222, 333, 444));
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    out_mode = 0;
    send(pk(-1, 2, -3, 4));                           wait_idle();

    // Back-to-back vectors with in_valid held.
    send(pk(1, 2, 3, 4));
    send(pk(5, 6, 7, 8));
    send(pk(9, 50000, 11, -50000));                   wait_idle();

    out_mode = 2;
    for (int i = 0; i < 40; i++) begin
      logic [N*AW-1:0] v;
      for (int k = 0; k < N; k++)
        v[k*AW +: AW] = ($urandom_range(0, 1) == 1) ? AW'($urandom) : AW'($urandom_range(0, 65535) - 32768);
      send(v);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
    end
    wait_idle();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
